// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a shared single-port memory.
// One command is issued per transaction; reads wait RD_LAT cycles and return registered data.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic              last_r;
    logic              win_r;
    logic              pick_s;
    logic              wr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata0_r;
    logic [DATA_W-1:0] rdata1_r;

    // Winner selection: a lone request wins, a tie goes to the port not served last.
    always_comb begin
        pick_s = 1'b0;
        if (m0_req && m1_req) begin
            pick_s = ~last_r;
        end else if (m1_req) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    next_state_s = S_ISSUE;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (wr_r) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    next_state_s = S_RESP;
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            S_RESP:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // Transaction latch, arbitration pointer, latency counter and read data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r   <= 1'b1;
            win_r    <= 1'b0;
            wr_r     <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= {DATA_W{1'b0}};
            rdata0_r <= {DATA_W{1'b0}};
            rdata1_r <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (m0_req || m1_req) begin
                        win_r   <= pick_s;
                        last_r  <= pick_s;
                        wr_r    <= pick_s ? m1_wr    : m0_wr;
                        addr_r  <= pick_s ? m1_addr  : m0_addr;
                        wdata_r <= pick_s ? m1_wdata : m0_wdata;
                    end
                end
                S_ISSUE: begin
                    if (!wr_r) begin
                        cnt_r <= CNT_W'(RD_LAT - 1);
                    end
                end
                S_WAIT: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - 2'd1;
                    end else if (win_r) begin
                        rdata1_r <= mem_rdata;
                    end else begin
                        rdata0_r <= mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode; every output derives only from registered state.
    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        case (state_r)
            S_ISSUE: begin
                m0_gnt = ~win_r;
                m1_gnt = win_r;
                mem_wr = wr_r;
                mem_rd = ~wr_r;
            end
            S_RESP: begin
                m0_rvalid = ~win_r;
                m1_rvalid = win_r;
            end
            default: begin
            end
        endcase
    end

    assign busy      = (state_r != S_IDLE);
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign m0_rdata  = rdata0_r;
    assign m1_rdata  = rdata1_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RD_LAT 1 and 3) with a memory model each,
// directed scenarios with literal expectations, then random traffic against a transaction-level model.
module tb_mem_arbiter;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clk;
    logic        rst     [2];
    logic        req     [2][2];
    logic        wr      [2][2];
    logic [15:0] addr    [2][2];
    logic [15:0] wdata   [2][2];
    logic        gnt     [2][2];
    logic        rvalid  [2][2];
    logic [15:0] rdata   [2][2];
    logic [15:0] maddr   [2];
    logic [15:0] mwdata  [2];
    logic        mrd     [2];
    logic        mwr     [2];
    logic [15:0] mrdata  [2];
    logic        busy    [2];

    logic [15:0] pipe    [2][4];
    bit   [15:0] em      [2][32];
    bit          emv     [2][32];

    int total;
    int bad;
    int cyc;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(LAT0)) dut0 (
        .clk(clk), .rst(rst[0]),
        .m0_req(req[0][0]), .m0_wr(wr[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
        .m1_req(req[0][1]), .m1_wr(wr[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
        .m0_gnt(gnt[0][0]), .m1_gnt(gnt[0][1]), .m0_rvalid(rvalid[0][0]), .m1_rvalid(rvalid[0][1]),
        .m0_rdata(rdata[0][0]), .m1_rdata(rdata[0][1]),
        .mem_addr(maddr[0]), .mem_wdata(mwdata[0]), .mem_rd(mrd[0]), .mem_wr(mwr[0]),
        .mem_rdata(mrdata[0]), .busy(busy[0])
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(LAT1)) dut1 (
        .clk(clk), .rst(rst[1]),
        .m0_req(req[1][0]), .m0_wr(wr[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
        .m1_req(req[1][1]), .m1_wr(wr[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
        .m0_gnt(gnt[1][0]), .m1_gnt(gnt[1][1]), .m0_rvalid(rvalid[1][0]), .m1_rvalid(rvalid[1][1]),
        .m0_rdata(rdata[1][0]), .m1_rdata(rdata[1][1]),
        .mem_addr(maddr[1]), .mem_wdata(mwdata[1]), .mem_rd(mrd[1]), .mem_wr(mwr[1]),
        .mem_rdata(mrdata[1]), .busy(busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int l);
        return (l == 0) ? LAT0 : LAT1;
    endfunction

    // Contents of a never-written memory word.
    function automatic logic [15:0] fmem(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Memory models: words indexed by addr[4:0], read data appears RD_LAT cycles after mem_rd.
    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (mwr[l] === 1'b1) begin
                em[l][maddr[l][4:0]]  <= mwdata[l];
                emv[l][maddr[l][4:0]] <= 1'b1;
            end
            if (mrd[l] === 1'b1) begin
                pipe[l][0] <= emv[l][maddr[l][4:0]] ? em[l][maddr[l][4:0]] : fmem(maddr[l]);
            end else begin
                pipe[l][0] <= 16'($urandom);
            end
            for (int i = 1; i < 4; i++) pipe[l][i] <= pipe[l][i-1];
        end
    end
    assign mrdata[0] = pipe[0][LAT0-1];
    assign mrdata[1] = pipe[1][LAT1-1];

    task automatic chk(input int l, input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL lane%0d %s: got %h expected %h (cycle %0d)", l, nm, got, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference model, checked against both DUTs on every falling edge.
    initial begin : model
        bit          armed [2];
        bit          act   [2];
        int          t0    [2];
        int          nidle [2];
        int          w     [2];
        bit          xwr   [2];
        logic [15:0] xad   [2];
        logic [15:0] xwd   [2];
        logic [15:0] xrd   [2];
        logic [15:0] la    [2];
        logic [15:0] lw    [2];
        logic [15:0] rdm   [2][2];
        bit          last  [2];
        bit   [15:0] mm    [2][32];
        bit          mmv   [2][32];
        int          mc;
        int          k;
        bit          eg0, eg1, ev0, ev1, erd, ewr, pk;
        mc = 0;
        forever begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                if (armed[l]) begin
                    if (act[l] && mc >= nidle[l]) act[l] = 1'b0;
                    k   = mc - t0[l];
                    eg0 = act[l] && k == 1 && w[l] == 0;
                    eg1 = act[l] && k == 1 && w[l] == 1;
                    ewr = act[l] && k == 1 && xwr[l];
                    erd = act[l] && k == 1 && !xwr[l];
                    ev0 = act[l] && !xwr[l] && k == lat(l) + 2 && w[l] == 0;
                    ev1 = act[l] && !xwr[l] && k == lat(l) + 2 && w[l] == 1;
                    if (ev0) rdm[l][0] = xrd[l];
                    if (ev1) rdm[l][1] = xrd[l];
                    chk(l, "busy", busy[l], act[l]);
                    chk(l, "m0_gnt", gnt[l][0], eg0);
                    chk(l, "m1_gnt", gnt[l][1], eg1);
                    chk(l, "m0_rvalid", rvalid[l][0], ev0);
                    chk(l, "m1_rvalid", rvalid[l][1], ev1);
                    chk(l, "m0_rdata", rdata[l][0], rdm[l][0]);
                    chk(l, "m1_rdata", rdata[l][1], rdm[l][1]);
                    chk(l, "mem_rd", mrd[l], erd);
                    chk(l, "mem_wr", mwr[l], ewr);
                    chk(l, "mem_addr", maddr[l], la[l]);
                    chk(l, "mem_wdata", mwdata[l], lw[l]);
                    if (ewr) begin
                        mm[l][xad[l][4:0]]  = xwd[l];
                        mmv[l][xad[l][4:0]] = 1'b1;
                    end
                    if (erd) xrd[l] = mmv[l][xad[l][4:0]] ? mm[l][xad[l][4:0]] : fmem(xad[l]);
                end
                if (rst[l] === 1'b1) begin
                    armed[l] = 1'b1;
                    act[l]   = 1'b0;
                    last[l]  = 1'b1;
                    la[l]    = 16'h0000;
                    lw[l]    = 16'h0000;
                    rdm[l][0] = 16'h0000;
                    rdm[l][1] = 16'h0000;
                end else if (armed[l] && !act[l] && (req[l][0] || req[l][1])) begin
                    if (req[l][0] && req[l][1]) pk = !last[l];
                    else pk = req[l][1];
                    last[l]  = pk;
                    w[l]     = pk ? 1 : 0;
                    xwr[l]   = wr[l][w[l]];
                    xad[l]   = addr[l][w[l]];
                    xwd[l]   = wdata[l][w[l]];
                    la[l]    = xad[l];
                    lw[l]    = xwd[l];
                    t0[l]    = mc;
                    nidle[l] = xwr[l] ? mc + 2 : mc + lat(l) + 3;
                    act[l]   = 1'b1;
                end
            end
            mc++;
        end
    end

    task automatic set_req(input int l, input int p, input logic r, input logic w_, input logic [15:0] a, input logic [15:0] d);
        req[l][p]   = r;
        wr[l][p]    = w_;
        addr[l][p]  = a;
        wdata[l][p] = d;
    endtask

    task automatic wait_idle(input int l);
        int n;
        n = 0;
        while (busy[l] && n < 20) begin
            tick;
            n++;
        end
        chk(l, "idle_within_bound", busy[l], 1'b0);
    endtask

    task automatic do_reset(input int l);
        rst[l] = 1'b1;
        tick;
        rst[l] = 1'b0;
        chk(l, "reset_busy", busy[l], 1'b0);
        chk(l, "reset_mem_addr", maddr[l], 16'h0000);
        chk(l, "reset_gnt", {gnt[l][0], gnt[l][1]}, 2'b00);
        chk(l, "reset_rdata", {rdata[l][0], rdata[l][1]}, 32'h0);
    endtask

    task automatic directed(input int l);
        int n, ng, i;
        logic [3:0] seq;
        do_reset(l);
        // single write from m0
        set_req(l, 0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        tick;
        chk(l, "wr_m0_gnt", gnt[l][0], 1'b1);
        chk(l, "wr_m1_gnt", gnt[l][1], 1'b0);
        chk(l, "wr_mem_wr", mwr[l], 1'b1);
        chk(l, "wr_mem_addr", maddr[l], 16'h0010);
        chk(l, "wr_mem_wdata", mwdata[l], 16'hBEEF);
        req[l][0] = 1'b0;
        tick;
        chk(l, "wr_busy_T2", busy[l], 1'b0);
        // single read from m1
        set_req(l, 1, 1'b1, 1'b0, 16'h0010, 16'h0000);
        tick;
        chk(l, "rd_m1_gnt", gnt[l][1], 1'b1);
        chk(l, "rd_mem_rd", mrd[l], 1'b1);
        req[l][1] = 1'b0;
        repeat (lat(l) + 1) tick;
        chk(l, "rd_m1_rvalid", rvalid[l][1], 1'b1);
        chk(l, "rd_m1_rdata", rdata[l][1], 16'hBEEF);
        chk(l, "rd_m0_rvalid", rvalid[l][0], 1'b0);
        tick;
        chk(l, "rd_busy_end", busy[l], 1'b0);
        // tie after reset: continuous reads from both ports
        do_reset(l);
        set_req(l, 0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        set_req(l, 1, 1'b1, 1'b0, 16'h0011, 16'h0000);
        n = 0; ng = 0; seq = 4'b0000;
        while (ng < 4 && n < 4 * (lat(l) + 3) + 6) begin
            tick;
            n++;
            if (gnt[l][0]) begin seq = {seq[2:0], 1'b0}; ng++; end
            if (gnt[l][1]) begin seq = {seq[2:0], 1'b1}; ng++; end
            if (rvalid[l][0]) chk(l, "tie_m0_rdata", rdata[l][0], 16'hBEEF);
            if (rvalid[l][1]) chk(l, "tie_m1_rdata", rdata[l][1], fmem(16'h0011));
        end
        req[l][0] = 1'b0;
        req[l][1] = 1'b0;
        chk(l, "tie_grant_count", ng, 4);
        chk(l, "tie_grant_order", seq, 4'b0101);
        wait_idle(l);
        // m1 request raised while an m0 read is waiting
        set_req(l, 0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        tick;
        chk(l, "busyreq_m0_gnt", gnt[l][0], 1'b1);
        req[l][0] = 1'b0;
        tick;
        set_req(l, 1, 1'b1, 1'b0, 16'h0010, 16'h0000);
        i = 2;
        while (!gnt[l][1] && i < 40) begin
            tick;
            i++;
        end
        chk(l, "busyreq_m1_gnt_offset", i, lat(l) + 4);
        req[l][1] = 1'b0;
        wait_idle(l);
        // reset while a read waits for memory
        set_req(l, 0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        tick;
        req[l][0] = 1'b0;
        tick;
        rst[l] = 1'b1;
        tick;
        rst[l] = 1'b0;
        chk(l, "rstmid_m0_rvalid", rvalid[l][0], 1'b0);
        chk(l, "rstmid_mem_rd", mrd[l], 1'b0);
        chk(l, "rstmid_busy", busy[l], 1'b0);
        chk(l, "rstmid_rdata", {rdata[l][0], rdata[l][1]}, 32'h0);
        set_req(l, 0, 1'b1, 1'b0, 16'h0012, 16'h0000);
        set_req(l, 1, 1'b1, 1'b0, 16'h0013, 16'h0000);
        tick;
        chk(l, "rstmid_tie_m0_gnt", gnt[l][0], 1'b1);
        chk(l, "rstmid_tie_m1_gnt", gnt[l][1], 1'b0);
        req[l][0] = 1'b0;
        n = 0;
        while (!gnt[l][1] && n < 20) begin
            tick;
            n++;
        end
        chk(l, "rstmid_m1_gnt_seen", gnt[l][1], 1'b1);
        req[l][1] = 1'b0;
        wait_idle(l);
    endtask

    task automatic requester(input int l, input int p, input int stop);
        int gap, n;
        while (cyc < stop) begin
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                req[l][p] = 1'b0;
                repeat (gap) tick;
            end
            set_req(l, p, 1'b1, 1'($urandom_range(0, 1)),
                    16'($urandom_range(0, 31)) | (($urandom_range(0, 3) == 0) ? 16'hA500 : 16'h0000),
                    16'($urandom));
            tick;
            n = 0;
            while (!gnt[l][p] && n < 300) begin
                tick;
                n++;
            end
            chk(l, $sformatf("gnt_within_bound_m%0d", p), gnt[l][p], 1'b1);
            tick;
        end
        req[l][p] = 1'b0;
    endtask

    task automatic resetter(input int l, input int stop);
        while (cyc < stop) begin
            rst[l] = ($urandom_range(0, 79) == 0);
            tick;
        end
        rst[l] = 1'b0;
    endtask

    initial begin : main
        int stop;
        for (int l = 0; l < 2; l++) begin
            rst[l] = 1'b1;
            for (int p = 0; p < 2; p++) set_req(l, p, 1'b0, 1'b0, 16'h0000, 16'h0000);
        end
        tick;
        tick;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        directed(0);
        directed(1);
        stop = cyc + 3000;
        fork
            requester(0, 0, stop);
            requester(0, 1, stop);
            requester(1, 0, stop);
            requester(1, 1, stop);
            resetter(0, stop);
            resetter(1, stop);
        join
        repeat (12) tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the shared single-port data/instruction memory. Port 0 is the CPU control/datapath memory port (fetch, LD, ST); port 1 is a secondary master (DMA/display/loader). The block serialises accesses with round-robin priority, issues one memory command per transaction, waits out the memory read latency and returns registered read data with a one-cycle valid pulse.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- RD_LAT, 1, memory read latency in cycles from mem_rd to valid mem_rdata; legal range 1..4

- clk  in  1  clock; everything is sampled on the rising edge
- rst  in  1  synchronous, active-high reset
- m0_req, m1_req  in  1  access request; held high with stable wr/addr/wdata until gnt
- m0_wr, m1_wr  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  ADDR_W  access address
- m0_wdata, m1_wdata  in  DATA_W  write data
- m0_gnt, m1_gnt  out  1  one-cycle pulse when that port's command is issued to memory
- m0_rvalid, m1_rvalid  out  1  one-cycle pulse: read data on mX_rdata is valid
- m0_rdata, m1_rdata  out  DATA_W  registered read data; holds until that port's next rvalid
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rd, mem_wr  out  1  memory command strobes, never both high
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_rd
- busy  out  1  high whenever state is not S_IDLE

## Operation
- States: S_IDLE, S_ISSUE, S_WAIT, S_RESP.
- S_IDLE: if any req is high, pick the winner, latch its wr, addr and wdata plus the winner id, then go to S_ISSUE. No req: stay.
- Arbitration: a single request wins outright. If both requests are high, the port not served last wins. The last-served pointer updates on every grant. After reset the pointer is 1, so port 0 wins the first tie.
- S_ISSUE: drive mem_addr and mem_wdata from the latched registers. Assert mem_wr or mem_rd for exactly this cycle. Pulse the winner's gnt.
  - Write: go to S_IDLE.
  - Read: load the wait counter with RD_LAT-1 and go to S_WAIT.
- S_WAIT: mem_rd low. Decrement the counter while it is non-zero. When it is 0, capture mem_rdata into the winner's rdata register at the end of that cycle and go to S_RESP.
- S_RESP: pulse the winner's rvalid, then go to S_IDLE.
- A request is committed once latched in S_IDLE. Requesters must not drop req before gnt; if they do, behaviour is undefined.
- Outside S_ISSUE: mem_rd and mem_wr are 0. mem_addr and mem_wdata hold their last latched values.
- Requests arriving in any state other than S_IDLE wait; they are evaluated on the next S_IDLE cycle.

## Timing
- Reset values: state S_IDLE; pointer 1; counter 0; latched registers 0. All outputs 0: gnt, rvalid, rdata, mem_* and busy.
- Write latency: req seen in cycle T (S_IDLE), gnt and mem_wr in T+1, S_IDLE again in T+2. Back-to-back writes take 2 cycles each.
- Read latency:
  - gnt and mem_rd in T+1.
  - mem_rdata captured at the end of T+RD_LAT+1.
  - rvalid and new rdata in T+RD_LAT+2.
  - S_IDLE in T+RD_LAT+3. Back-to-back reads take RD_LAT+3 cycles each.
- Simultaneous requests: strictly alternate while both stay asserted.
- Reset mid-transaction (any state): state returns to S_IDLE on the next edge. The pending read is aborted, with no rvalid. mem_rd and mem_wr are low from the cycle after rst is sampled. rdata clears to 0.
- gnt and rvalid are never high for both ports in the same cycle.

## Test plan
- Reset then single write: m0 write addr 0x0010, data 0xBEEF at T -> m0_gnt=1, mem_wr=1, mem_addr=0x0010, mem_wdata=0xBEEF at T+1; busy low at T+2; m1_gnt never asserted.
- Single read, RD_LAT=1 and RD_LAT=3: m1 reads 0x0010 with the memory model returning 0xBEEF -> m1_gnt at T+1, m1_rvalid=1 with m1_rdata=0xBEEF at T+3 (RD_LAT=1) / T+5 (RD_LAT=3); m0_rvalid stays 0.
- Tie after reset: m0 and m1 both read continuously -> grant order m0, m1, m0, m1; each rvalid routed to the matching port with the correct data.
- Request during busy: m1 req asserted while an m0 read is in S_WAIT -> m1 not granted until the cycle after the S_RESP->S_IDLE return; m1_gnt is exactly 1 cycle after that S_IDLE cycle.
- Reset mid-read: assert rst during S_WAIT with RD_LAT=3 -> no rvalid, mem_rd=0, busy=0 and rdata=0 next cycle; a subsequent m0/m1 tie is won by m0.
- Protocol checks throughout: mem_rd and mem_wr never both high; gnt is a single-cycle pulse; one gnt per committed request.
